// File: rtl/sb_pkg.sv
// Shared-buffer read-path definitions: descriptor layout, port count and the
// out-of-queue-cache read arbiter state encoding.
package sb_pkg;

    localparam int DESC_W    = 32;
    localparam int ADDR_W    = 16;
    localparam int LEN_W     = 8;
    localparam int NUM_PORTS = 4;
    localparam int PORT_W    = 2;

    // Descriptor field offsets; bits above the length field are reserved.
    localparam int DESC_ADDR_LSB = 0;
    localparam int DESC_LEN_LSB  = ADDR_W;
    localparam int DESC_USED_W   = ADDR_W + LEN_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_POP   = 2'd1,
        ST_LOAD  = 2'd2,
        ST_BURST = 2'd3
    } rd_state_e;

    // Cell start address from the used (non-reserved) part of a descriptor.
    function automatic logic [ADDR_W-1:0] desc_addr(input logic [DESC_USED_W-1:0] desc_lo);
        return desc_lo[DESC_ADDR_LSB +: ADDR_W];
    endfunction

    // Packet length in cells from the used (non-reserved) part of a descriptor.
    function automatic logic [LEN_W-1:0] desc_len(input logic [DESC_USED_W-1:0] desc_lo);
        return desc_lo[DESC_LEN_LSB +: LEN_W];
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational four-way round-robin grant: the search starts at ptr and
// wraps 3 -> 0; the first requester found wins.
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt_onehot,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);
    import sb_pkg::*;

    logic [1:0] cand_s;

    // Scan the four candidates in rotated order and keep the first hit.
    always_comb begin
        gnt_onehot = 4'b0000;
        gnt_idx    = 2'd0;
        gnt_valid  = 1'b0;
        cand_s     = 2'd0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand_s = ptr + 2'(i);
            if (!gnt_valid && req[cand_s]) begin
                gnt_valid          = 1'b1;
                gnt_idx            = cand_s;
                gnt_onehot[cand_s] = 1'b1;
            end else begin
                gnt_valid = gnt_valid;
            end
        end
    end

endmodule

// File: rtl/ooqc_rd_arbiter.sv
// Read arbiter for one crossbar output column: picks an out-of-queue cache
// round-robin, pops one descriptor and issues one shared-buffer read per cell.
module ooqc_rd_arbiter #(
    parameter int DESC_W = 32,
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [3:0]            i_ooqc_empty,
    input  logic [4*DESC_W-1:0]   i_ooqc_dat,
    output logic [3:0]            o_ooqc_rd_en,
    input  logic [3:0]            i_port_ready,
    output logic                  o_mem_rd_en,
    output logic [ADDR_W-1:0]     o_mem_rd_addr,
    output logic [1:0]            o_mem_rd_port,
    output logic                  o_mem_rd_last,
    input  logic                  i_mem_rdy,
    output logic                  o_pkt_done,
    output logic                  o_len_err,
    output logic                  o_busy
);
    import sb_pkg::*;

    localparam int USED_W = ADDR_W + LEN_W;

    rd_state_e             state_r,  state_s;
    logic [1:0]            rr_ptr_r, rr_ptr_s;
    logic [1:0]            grant_r,  grant_s;
    logic [ADDR_W-1:0]     addr_r,   addr_s;
    logic [LEN_W-1:0]      cnt_r,    cnt_s;

    logic [3:0]            rd_en_r,    rd_en_s;
    logic                  mem_en_r,   mem_en_s;
    logic [ADDR_W-1:0]     mem_addr_r;
    logic [1:0]            mem_port_r;
    logic                  mem_last_r, mem_last_s;
    logic                  done_r,     done_s;
    logic                  len_err_r,  len_err_s;
    logic                  busy_r;

    logic [3:0]            elig_s;
    logic [3:0]            gnt_onehot_s;
    logic [1:0]            gnt_idx_s;
    logic                  gnt_valid_s;
    logic [USED_W-1:0]     cur_desc_s;
    logic [ADDR_W-1:0]     desc_addr_s;
    logic [LEN_W-1:0]      desc_len_s;

    // Empty/ready are only consulted while IDLE, so a burst in flight is never
    // disturbed by them.
    assign elig_s = ~i_ooqc_empty & i_port_ready;

    rr_arbiter4 u_rr (
        .req        (elig_s),
        .ptr        (rr_ptr_r),
        .gnt_onehot (gnt_onehot_s),
        .gnt_idx    (gnt_idx_s),
        .gnt_valid  (gnt_valid_s)
    );

    // Descriptor of the granted cache; only address and length are used.
    assign cur_desc_s  = i_ooqc_dat[grant_r*DESC_W +: USED_W];
    assign desc_addr_s = cur_desc_s[ADDR_W-1:0];
    assign desc_len_s  = cur_desc_s[ADDR_W +: LEN_W];

    // Next-state and next-output computation for the pop/load/burst sequence.
    always_comb begin
        state_s   = state_r;
        rr_ptr_s  = rr_ptr_r;
        grant_s   = grant_r;
        addr_s    = addr_r;
        cnt_s     = cnt_r;
        rd_en_s   = 4'b0000;
        done_s    = 1'b0;
        len_err_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (gnt_valid_s) begin
                    state_s  = ST_POP;
                    grant_s  = gnt_idx_s;
                    rr_ptr_s = gnt_idx_s + 2'd1;
                    rd_en_s  = gnt_onehot_s;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_POP: begin
                // Standard-read cache: dout is valid the cycle after the pop.
                state_s = ST_LOAD;
            end
            ST_LOAD: begin
                addr_s = desc_addr_s;
                cnt_s  = desc_len_s;
                if (desc_len_s == {LEN_W{1'b0}}) begin
                    len_err_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    state_s   = ST_BURST;
                end
            end
            ST_BURST: begin
                if (i_mem_rdy) begin
                    addr_s = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    cnt_s  = cnt_r - {{(LEN_W-1){1'b0}}, 1'b1};
                    if (cnt_r == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_BURST;
                    end
                end else begin
                    state_s = ST_BURST;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // The request registers mirror the next burst state, so fields stay
        // put while the memory withholds i_mem_rdy.
        mem_en_s   = (state_s == ST_BURST);
        mem_last_s = (state_s == ST_BURST) && (cnt_s == {{(LEN_W-1){1'b0}}, 1'b1});
    end

    // State, pointer, burst bookkeeping and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= 2'd0;
            grant_r    <= 2'd0;
            addr_r     <= {ADDR_W{1'b0}};
            cnt_r      <= {LEN_W{1'b0}};
            rd_en_r    <= 4'b0000;
            mem_en_r   <= 1'b0;
            mem_addr_r <= {ADDR_W{1'b0}};
            mem_port_r <= 2'd0;
            mem_last_r <= 1'b0;
            done_r     <= 1'b0;
            len_err_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            rr_ptr_r   <= rr_ptr_s;
            grant_r    <= grant_s;
            addr_r     <= addr_s;
            cnt_r      <= cnt_s;
            rd_en_r    <= rd_en_s;
            mem_en_r   <= mem_en_s;
            mem_addr_r <= addr_s;
            mem_port_r <= grant_s;
            mem_last_r <= mem_last_s;
            done_r     <= done_s;
            len_err_r  <= len_err_s;
            busy_r     <= (state_s != ST_IDLE);
        end
    end

    assign o_ooqc_rd_en  = rd_en_r;
    assign o_mem_rd_en   = mem_en_r;
    assign o_mem_rd_addr = mem_addr_r;
    assign o_mem_rd_port = mem_port_r;
    assign o_mem_rd_last = mem_last_r;
    assign o_pkt_done    = done_r;
    assign o_len_err     = len_err_r;
    assign o_busy        = busy_r;

endmodule

// File: tb/tb_ooqc_rd_arbiter.sv
// Self-checking bench for ooqc_rd_arbiter: behavioural cache FIFOs, a
// queue-based reference model of grant order and cell stream, directed timing
// checks and randomized traffic with random memory back-pressure.
module tb_ooqc_rd_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   ooqc_empty = 4'hF;
    logic [127:0] ooqc_dat = '0;
    logic [3:0]   ooqc_rd_en;
    logic [3:0]   port_ready = 4'h0;
    logic         mem_rd_en;
    logic [15:0]  mem_rd_addr;
    logic [1:0]   mem_rd_port;
    logic         mem_rd_last;
    logic         mem_rdy = 1'b0;
    logic         pkt_done;
    logic         len_err;
    logic         busy;

    always #5 clk = ~clk;

    ooqc_rd_arbiter dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_ooqc_empty  (ooqc_empty),
        .i_ooqc_dat    (ooqc_dat),
        .o_ooqc_rd_en  (ooqc_rd_en),
        .i_port_ready  (port_ready),
        .o_mem_rd_en   (mem_rd_en),
        .o_mem_rd_addr (mem_rd_addr),
        .o_mem_rd_port (mem_rd_port),
        .o_mem_rd_last (mem_rd_last),
        .i_mem_rdy     (mem_rdy),
        .o_pkt_done    (pkt_done),
        .o_len_err     (len_err),
        .o_busy        (busy)
    );

    // Behavioural caches: contents in queues, dout updates the cycle after rd_en.
    logic [31:0] q [4][$];

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (ooqc_rd_en[k] === 1'b1 && q[k].size() > 0)
                ooqc_dat[k*32 +: 32] <= q[k].pop_front();
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++)
            ooqc_empty[k] <= (q[k].size() == 0);
    end

    // Scoreboard state.
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          mptr     = 0;
    int          exp_grants [$];
    logic [31:0] exp_cells  [$];
    int          act_grants [$];
    logic [15:0] act_addrs  [$];
    int          done_cycles [$];
    int          exp_len_err  = 0;
    int          seen_len_err = 0;
    int          req_cycles   = 0;
    int          n_accept     = 0;
    logic        exp_done     = 1'b0;
    logic        held_valid   = 1'b0;
    logic [31:0] held_req     = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k, input logic [15:0] a, input logic [7:0] len);
        q[k].push_back({8'($urandom), len, a});
    endtask

    // Reference model: replay round-robin arbitration over the queued
    // descriptors and the current ready mask, producing grants and cells.
    task automatic plan();
        logic [31:0] cp [4][$];
        logic [31:0] d;
        int          g;
        int          k;
        int          len;
        bit          found;
        for (int p = 0; p < 4; p++) cp[p] = q[p];
        found = 1'b1;
        while (found) begin
            found = 1'b0;
            g = 0;
            for (int i = 0; i < 4; i++) begin
                k = (mptr + i) % 4;
                if (!found && cp[k].size() > 0 && port_ready[k]) begin
                    found = 1'b1;
                    g = k;
                end
            end
            if (found) begin
                d = cp[g].pop_front();
                exp_grants.push_back(g);
                mptr = (g + 1) % 4;
                len = int'(d[23:16]);
                if (len == 0) exp_len_err++;
                for (int j = 0; j < len; j++)
                    exp_cells.push_back({13'd0, (j == len - 1), 2'(g), 16'(d[15:0] + 16'(j))});
            end
        end
    endtask

    // One clock: sample outputs after the edge, check them, then drive mem_rdy.
    task automatic step(input logic rdy);
        logic [31:0] cur;
        logic [31:0] exp_c;
        logic [3:0]  exp_oh;
        int          g;
        @(posedge clk);
        #1;
        cyc++;
        cur = {13'd0, mem_rd_last, mem_rd_port, mem_rd_addr};
        if (ooqc_rd_en !== 4'b0000) begin
            exp_oh = 4'b0000;
            if (exp_grants.size() > 0) begin
                g = exp_grants.pop_front();
                exp_oh[g] = 1'b1;
            end
            chk("grant", 32'(ooqc_rd_en), 32'(exp_oh));
            for (int k = 0; k < 4; k++)
                if (ooqc_rd_en[k]) act_grants.push_back(k);
        end
        if (held_valid) begin
            chk("hold_en", 32'(mem_rd_en), 32'd1);
            chk("hold_req", cur, held_req);
        end
        chk("pkt_done", 32'(pkt_done), 32'(exp_done));
        if (len_err) seen_len_err++;
        if (pkt_done) done_cycles.push_back(cyc);
        if (mem_rd_en) req_cycles++;
        mem_rdy    = rdy;
        exp_done   = 1'b0;
        held_valid = mem_rd_en && !rdy;
        held_req   = cur;
        if (mem_rd_en && rdy) begin
            n_accept++;
            act_addrs.push_back(mem_rd_addr);
            if (exp_cells.size() > 0) exp_c = exp_cells.pop_front();
            else exp_c = 32'hDEAD_BEEF;
            chk("cell", cur, exp_c);
            exp_done = exp_c[18];
        end
    endtask

    task automatic drain(input int budget, input bit rnd);
        int n;
        n = 0;
        do begin
            step(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            n++;
        end while ((busy || exp_done || exp_cells.size() != 0 || exp_grants.size() != 0) && n < budget);
        chk("drain_in_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic end_checks();
        chk("cells_left", 32'(exp_cells.size()), 32'd0);
        chk("grants_left", 32'(exp_grants.size()), 32'd0);
        chk("len_err_count", 32'(seen_len_err), 32'(exp_len_err));
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b1;
        exp_cells.delete();
        exp_grants.delete();
        exp_done    = 1'b0;
        held_valid  = 1'b0;
        mptr        = 0;
        exp_len_err = seen_len_err;
        repeat (cycles) step(1'b0);
        chk("rst_outs", {5'd0, ooqc_rd_en, mem_rd_en, mem_rd_addr, mem_rd_port,
                         mem_rd_last, pkt_done, len_err, busy}, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        int n1;
        int p1_grants;

        // Power-on reset.
        apply_reset(3);
        port_ready = 4'hF;
        step(1'b1);

        // Single packet on port 2: addr 0x0100, 3 cells.
        push(2, 16'h0100, 8'd3);
        plan();
        step(1'b1);
        chk("sp_rd_en_c1", 32'(ooqc_rd_en), 32'h4);
        step(1'b1);
        chk("sp_no_req_c2", 32'(mem_rd_en), 32'd0);
        for (int c = 3; c <= 5; c++) begin
            step(1'b1);
            chk("sp_req", {mem_rd_en, 13'd0, mem_rd_port, mem_rd_addr},
                {1'b1, 13'd0, 2'd2, 16'(16'h0100 + 16'(c - 3))});
            chk("sp_last", 32'(mem_rd_last), 32'(c == 5));
        end
        step(1'b1);
        chk("sp_done_c6", 32'(pkt_done), 32'd1);
        drain(50, 1'b0);
        end_checks();

        // Round-robin fairness: two single-cell descriptors per cache.
        apply_reset(1);
        act_grants.delete();
        done_cycles.delete();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 4; k++) push(k, 16'(16'h1000 + 16'(r * 4 + k)), 8'd1);
        plan();
        drain(200, 1'b0);
        end_checks();
        chk("rr_count", 32'(act_grants.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk("rr_order", 32'(act_grants[i]), 32'(i % 4));
        chk("done_count", 32'(done_cycles.size()), 32'd8);
        // One bus cycle plus IDLE, POP and LOAD between consecutive packets.
        for (int i = 1; i < 8; i++)
            chk("done_spacing", 32'(done_cycles[i] - done_cycles[i-1]), 32'd4);

        // Back-pressure: first cell stalled for three cycles.
        req_cycles = 0;
        n_accept   = 0;
        push(1, 16'h0200, 8'd2);
        plan();
        step(1'b1);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        step(1'b1);
        drain(50, 1'b0);
        end_checks();
        chk("bp_req_cycles", 32'(req_cycles), 32'd5);
        chk("bp_accepted", 32'(n_accept), 32'd2);

        // Address wrap.
        act_addrs.delete();
        push(3, 16'hFFFF, 8'd2);
        plan();
        drain(50, 1'b0);
        end_checks();
        chk("wrap_count", 32'(act_addrs.size()), 32'd2);
        chk("wrap_a0", 32'(act_addrs[0]), 32'h0000FFFF);
        chk("wrap_a1", 32'(act_addrs[1]), 32'h00000000);

        // Zero-length descriptor on port 1 followed by a packet on port 2.
        apply_reset(1);
        req_cycles = 0;
        push(1, 16'h0300, 8'd0);
        push(2, 16'h0400, 8'd1);
        plan();
        step(1'b1);
        chk("le_rd_en_c1", 32'(ooqc_rd_en), 32'h2);
        step(1'b1);
        step(1'b1);
        chk("le_err_c3", 32'(len_err), 32'd1);
        chk("le_no_req_c3", 32'(mem_rd_en), 32'd0);
        step(1'b1);
        chk("le_next_pop_c4", 32'(ooqc_rd_en), 32'h4);
        chk("le_no_req_before_next", 32'(req_cycles), 32'd0);
        drain(50, 1'b0);
        end_checks();

        // Mid-burst reset; afterwards the pointer restarts at port 0.
        push(0, 16'h0500, 8'd8);
        plan();
        repeat (5) step(1'b1);
        chk("mb_in_burst", 32'(mem_rd_en), 32'd1);
        push(0, 16'h0600, 8'd1);
        push(2, 16'h0700, 8'd1);
        apply_reset(1);
        plan();
        step(1'b1);
        chk("mb_first_grant", 32'(ooqc_rd_en), 32'h1);
        drain(50, 1'b0);
        end_checks();

        // Randomized traffic; first round keeps port 1 not ready.
        for (int r = 0; r < 4; r++) begin
            act_grants.delete();
            port_ready = (r == 0) ? 4'b1101 : 4'b1111;
            n1 = 0;
            for (int k = 0; k < 4; k++) begin
                int n;
                n = $urandom_range(1, 3);
                if (k == 1) n1 = n;
                for (int j = 0; j < n; j++)
                    push(k, ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom),
                         8'($urandom_range(0, 4)));
            end
            plan();
            drain(3000, 1'b1);
            end_checks();
            if (r == 0) begin
                p1_grants = 0;
                foreach (act_grants[i]) if (act_grants[i] == 1) p1_grants++;
                chk("inelig_p1_grants", 32'(p1_grants), 32'd0);
                chk("inelig_p1_kept", 32'(q[1].size()), 32'(n1));
                q[1].delete();
                step(1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
